// File: rtl/sprite_motion_ctrl.sv
// Frame-paced sprite position controller: keyboard-driven moves with hold acceleration.
// Define SPRITE_WRAP_EN to wrap around the visible area instead of clamping at its bounds.
module sprite_motion_ctrl #(
  parameter int         POS_W        = 10,
  parameter int         H_RES        = 640,
  parameter int         V_RES        = 480,
  parameter int         SPRITE_W     = 16,
  parameter int         SPRITE_H     = 16,
  parameter int         X_INIT       = 312,
  parameter int         Y_INIT       = 232,
  parameter int         STEP_MIN     = 1,
  parameter int         STEP_MAX     = 4,
  parameter int         ACCEL_FRAMES = 8,
  parameter logic [7:0] KEY_UP       = 8'h75,
  parameter logic [7:0] KEY_DOWN     = 8'h72,
  parameter logic [7:0] KEY_LEFT     = 8'h6B,
  parameter logic [7:0] KEY_RIGHT    = 8'h74
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       key_code,
  input  logic             frame_tick,
  input  logic             recenter,
  output logic [POS_W-1:0] sprite_x,
  output logic [POS_W-1:0] sprite_y,
  output logic [2:0]       step,
  output logic             moving,
  output logic [3:0]       at_edge
);
  localparam logic [POS_W:0]   X_MAX   = (POS_W+1)'(H_RES - SPRITE_W);
  localparam logic [POS_W:0]   Y_MAX   = (POS_W+1)'(V_RES - SPRITE_H);
  localparam int               CNT_W   = $clog2(ACCEL_FRAMES + 1);
  localparam logic [2:0]       STEP_LO = 3'(STEP_MIN);
  localparam logic [2:0]       STEP_HI = 3'(STEP_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ACCEL_FRAMES);

  typedef enum logic {IDLE, MOVE} state_t;
  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t           state, state_nxt;
  dir_t             last_dir, last_dir_nxt, dir, move_dir;
  logic [POS_W-1:0] pos_x, pos_y, pos_x_nxt, pos_y_nxt;
  logic [2:0]       step_q, step_nxt, move_amt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt, hold_inc;
  logic             move_en;

  function automatic dir_t decode_key(input logic [7:0] code);
    dir_t d;
    d = DIR_NONE;
    if (code == KEY_UP)         d = DIR_UP;
    else if (code == KEY_DOWN)  d = DIR_DOWN;
    else if (code == KEY_LEFT)  d = DIR_LEFT;
    else if (code == KEY_RIGHT) d = DIR_RIGHT;
    return d;
  endfunction

  // One axis step toward 0 (inc=0) or toward lim (inc=1), one guard bit wide.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic [2:0]       amt,
                                                input logic             inc,
                                                input logic [POS_W:0]   lim);
    logic [POS_W:0] p, a, r, span;
    p    = {1'b0, pos};
    a    = (POS_W+1)'(amt);
    span = lim + (POS_W+1)'(1);
    r    = '0;
    if (inc) begin
      r = p + a;
`ifdef SPRITE_WRAP_EN
      if (r > lim) r = r - span;
`else
      if (r > lim) r = lim;
`endif
    end else begin
`ifdef SPRITE_WRAP_EN
      r = (p < a) ? p - a + span : p - a;
`else
      r = (p < a) ? '0 : p - a;
`endif
    end
    return r[POS_W-1:0];
  endfunction

  function automatic logic [2:0] step_up(input logic [2:0] s);
    return (s >= STEP_HI) ? STEP_HI : s + 3'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      last_dir <= DIR_NONE;
      pos_x    <= POS_W'(X_INIT);
      pos_y    <= POS_W'(Y_INIT);
      step_q   <= STEP_LO;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_dir <= last_dir_nxt;
      pos_x    <= pos_x_nxt;
      pos_y    <= pos_y_nxt;
      step_q   <= step_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir;
    pos_x_nxt    = pos_x;
    pos_y_nxt    = pos_y;
    step_nxt     = step_q;
    hold_cnt_nxt = hold_cnt;
    move_en      = 1'b0;
    move_dir     = DIR_NONE;
    move_amt     = STEP_LO;
    dir          = decode_key(key_code);
    hold_inc     = hold_cnt + CNT_W'(1);
    if (recenter) begin
      state_nxt    = IDLE;
      pos_x_nxt    = POS_W'(X_INIT);
      pos_y_nxt    = POS_W'(Y_INIT);
      step_nxt     = STEP_LO;
      hold_cnt_nxt = '0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (dir != DIR_NONE) begin
            move_en      = 1'b1;
            move_dir     = dir;
            last_dir_nxt = dir;
            hold_cnt_nxt = CNT_W'(1);
            step_nxt     = STEP_LO;
            state_nxt    = MOVE;
          end
        end
        MOVE: begin
          if (dir == DIR_NONE) begin
            state_nxt    = IDLE;
            step_nxt     = STEP_LO;
            hold_cnt_nxt = '0;
          end else if (dir == last_dir) begin
            move_en  = 1'b1;
            move_dir = dir;
            move_amt = step_q;
            // Acceleration takes effect on the following tick.
            if (hold_inc == CNT_TOP) begin
              hold_cnt_nxt = '0;
              step_nxt     = step_up(step_q);
            end else begin
              hold_cnt_nxt = hold_inc;
            end
          end else begin
            move_en      = 1'b1;
            move_dir     = dir;
            last_dir_nxt = dir;
            step_nxt     = STEP_LO;
            hold_cnt_nxt = CNT_W'(1);
          end
        end
      endcase
    end
    if (move_en) begin
      case (move_dir)
        DIR_UP:    pos_y_nxt = step_pos(pos_y, move_amt, 1'b0, Y_MAX);
        DIR_DOWN:  pos_y_nxt = step_pos(pos_y, move_amt, 1'b1, Y_MAX);
        DIR_LEFT:  pos_x_nxt = step_pos(pos_x, move_amt, 1'b0, X_MAX);
        DIR_RIGHT: pos_x_nxt = step_pos(pos_x, move_amt, 1'b1, X_MAX);
        default:   ;
      endcase
    end
  end

  assign sprite_x = pos_x;
  assign sprite_y = pos_y;
  assign step     = step_q;
  assign moving   = (state == MOVE);
  assign at_edge  = {({1'b0, pos_y} == Y_MAX), (pos_y == '0),
                     ({1'b0, pos_x} == X_MAX), (pos_x == '0)};

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: driver queues expected outputs, monitor checks them.
module tb_sprite_motion_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] key_code;
  logic       frame_tick;
  logic       recenter;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [2:0] step;
  logic       moving;
  logic [3:0] at_edge;

  typedef struct {
    int         tag;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] s;
    logic       mv;
    logic [3:0] e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;
  logic chk_req = 1'b0;
  logic sample_pending = 1'b0;
  event async_chk;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_code   (key_code),
    .frame_tick (frame_tick),
    .recenter   (recenter),
    .sprite_x   (sprite_x),
    .sprite_y   (sprite_y),
    .step       (step),
    .moving     (moving),
    .at_edge    (at_edge)
  );

  function automatic logic [3:0] edges(input int x, input int y);
    return {(y == 464), (y == 0), (x == 624), (x == 0)};
  endfunction

  // Displacement after k consecutive held ticks starting from IDLE (1,2,3 then 4 px/frame).
  function automatic int disp(input int k);
    if (k <= 8)  return k;
    if (k <= 16) return 8 + 2 * (k - 8);
    if (k <= 24) return 24 + 3 * (k - 16);
    return 48 + 4 * (k - 24);
  endfunction

  function automatic int sstep(input int k);
    if (k < 8)  return 1;
    if (k < 16) return 2;
    if (k < 24) return 3;
    return 4;
  endfunction

  task automatic compare_front();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_sample got x=%0d y=%0d with no queued expectation", sprite_x, sprite_y);
      return;
    end
    e = sb.pop_front();
    if (sprite_x !== e.x || sprite_y !== e.y || step !== e.s || moving !== e.mv || at_edge !== e.e) begin
      errors++;
      $display("FAIL chk%0d got x=%0d y=%0d step=%0d moving=%b edge=%b want x=%0d y=%0d step=%0d moving=%b edge=%b",
               e.tag, sprite_x, sprite_y, step, moving, at_edge, e.x, e.y, e.s, e.mv, e.e);
    end
  endtask

  always @(posedge clk) sample_pending <= frame_tick | recenter | chk_req;
  always @(negedge clk) if (sample_pending) compare_front();
  initial forever begin
    @(async_chk);
    compare_front();
  end

  task automatic push(input int x, input int y, input int s, input logic mv);
    exp_t e;
    tag_n++;
    e.tag = tag_n;
    e.x   = 10'(x);
    e.y   = 10'(y);
    e.s   = 3'(s);
    e.mv  = mv;
    e.e   = edges(x, y);
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] k, input logic ft, input logic rc,
                       input int x, input int y, input int s, input logic mv);
    @(negedge clk);
    key_code   = k;
    frame_tick = ft;
    recenter   = rc;
    chk_req    = !(ft || rc);
    push(x, y, s, mv);
    @(negedge clk);
    frame_tick = 1'b0;
    recenter   = 1'b0;
    chk_req    = 1'b0;
  endtask

  task automatic hold_dir(input logic [7:0] k, input int n, input int x0, input int y0,
                          input int dx, input int dy);
    for (int i = 1; i <= n; i++)
      drive(k, 1'b1, 1'b0, x0 + dx * disp(i), y0 + dy * disp(i), sstep(i), 1'b1);
  endtask

  initial begin
    reset_n    = 1'b0;
    key_code   = 8'h00;
    frame_tick = 1'b0;
    recenter   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 312, 232, 1, 1'b0);

    hold_dir(8'h74, 3, 312, 232, 1, 0);
    @(negedge clk) key_code = 8'h6B;
    repeat (3) @(negedge clk);
    drive(8'h6B, 1'b0, 1'b0, 315, 232, 1, 1'b1);
    drive(8'h1C, 1'b1, 1'b0, 315, 232, 1, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 312, 232, 1, 1'b0);

    hold_dir(8'h6B, 20, 312, 232, -1, 0);
    drive(8'h00, 1'b1, 1'b0, 276, 232, 1, 1'b0);

    drive(8'h00, 1'b0, 1'b1, 312, 232, 1, 1'b0);
    drive(8'h75, 1'b1, 1'b0, 312, 231, 1, 1'b1);
    drive(8'h00, 1'b1, 1'b0, 312, 231, 1, 1'b0);
    hold_dir(8'h75, 69, 312, 231, 0, -1);
`ifdef SPRITE_WRAP_EN
    drive(8'h75, 1'b1, 1'b0, 312, 464, 4, 1'b1);
    drive(8'h75, 1'b1, 1'b0, 312, 460, 4, 1'b1);
`else
    drive(8'h75, 1'b1, 1'b0, 312, 0, 4, 1'b1);
    drive(8'h75, 1'b1, 1'b0, 312, 0, 4, 1'b1);
`endif

    drive(8'h00, 1'b0, 1'b1, 312, 232, 1, 1'b0);
    hold_dir(8'h74, 90, 312, 232, 1, 0);
`ifdef SPRITE_WRAP_EN
    drive(8'h74, 1'b1, 1'b0, 3, 232, 4, 1'b1);
    drive(8'h00, 1'b1, 1'b0, 3, 232, 1, 1'b0);
`else
    drive(8'h74, 1'b1, 1'b0, 624, 232, 4, 1'b1);
    drive(8'h00, 1'b1, 1'b0, 624, 232, 1, 1'b0);
`endif

    drive(8'h00, 1'b0, 1'b1, 312, 232, 1, 1'b0);
    hold_dir(8'h74, 17, 312, 232, 1, 0);
    hold_dir(8'h72, 8, 339, 232, 0, 1);

    drive(8'h74, 1'b1, 1'b1, 312, 232, 1, 1'b0);

    hold_dir(8'h6B, 9, 312, 232, -1, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    push(312, 232, 1, 1'b0);
    ->async_chk;
    @(negedge clk) reset_n = 1'b1;
    drive(8'h6B, 1'b1, 1'b0, 311, 232, 1, 1'b1);

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d unchecked entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
